// File: rtl/mac_seq.sv
// MAC array sequencer: walks G groups of K terms, issuing fetches, lane enables and writes.
// Define MAC_SEQ_BIAS_EN to select the bias word as the first-term partial-sum source.
module mac_seq #(
  parameter int MAC_NUM = 120,
  parameter int CW      = 10,
  parameter int AW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CW-1:0]      num_terms,
  input  logic [CW-1:0]      num_groups,
  input  logic [MAC_NUM-1:0] lane_mask,
  input  logic               result_vld,
  output logic               rd_en,
  output logic [AW-1:0]      img_addr,
  output logic [AW-1:0]      ker_addr,
  output logic [MAC_NUM-1:0] mac_en,
  output logic [1:0]         psum_sel,
  output logic               out_wr,
  output logic [CW-1:0]      out_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE
  } state_t;

`ifdef MAC_SEQ_BIAS_EN
  localparam logic [1:0] FIRST_SEL = 2'd2;
`else
  localparam logic [1:0] FIRST_SEL = 2'd0;
`endif

  state_t             state_q, state_d;
  logic [CW-1:0]      k_q, k_d;
  logic [CW-1:0]      gn_q, gn_d;
  logic [CW-1:0]      t_q, t_d;
  logic [CW-1:0]      grp_q, grp_d;
  logic [AW-1:0]      base_q, base_d;
  logic [MAC_NUM-1:0] mask_q, mask_d;
  logic [2:0]         wd_q, wd_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               more_terms;
  logic               more_groups;

  assign more_terms  = ({1'b0, t_q} + (CW+1)'(1)) < {1'b0, k_q};
  assign more_groups = ({1'b0, grp_q} + (CW+1)'(1)) < {1'b0, gn_q};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    gn_d    = gn_q;
    t_d     = t_q;
    grp_d   = grp_q;
    base_d  = base_q;
    mask_d  = mask_q;
    wd_d    = wd_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = (num_terms == '0) ? CW'(1) : num_terms;
          gn_d    = (num_groups == '0) ? CW'(1) : num_groups;
          mask_d  = lane_mask;
          t_d     = '0;
          grp_d   = '0;
          base_d  = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (result_vld) begin
          if (more_terms) begin
            t_d     = t_q + CW'(1);
            state_d = S_FETCH;
          end else begin
            t_d     = '0;
            state_d = S_WRITE;
          end
        end else if (wd_q == 3'd3) begin
          // result overdue: abandon the job without writing this group
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 3'd1;
        end
      end
      S_WRITE: begin
        t_d = '0;
        if (more_groups) begin
          grp_d   = grp_q + CW'(1);
          base_d  = base_q + AW'(k_q);
          state_d = S_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      gn_q    <= '0;
      t_q     <= '0;
      grp_q   <= '0;
      base_q  <= '0;
      mask_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      gn_q    <= gn_d;
      t_q     <= t_d;
      grp_q   <= grp_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign rd_en    = (state_q == S_FETCH);
  assign mac_en   = (state_q == S_ISSUE) ? mask_q : '0;
  assign out_wr   = (state_q == S_WRITE);
  assign out_addr = grp_q;
  assign img_addr = base_q + AW'(t_q);
  assign ker_addr = AW'(t_q);
  assign psum_sel = !busy        ? 2'd0 :
                    (t_q != '0)  ? 2'd1 : FIRST_SEL;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: job-level timing model, random jobs,
// ignored start, mid-job reset and watchdog timeout.
module tb_mac_seq;

  localparam int MN = 120;
  localparam int CW = 10;
  localparam int AW = 16;
`ifdef MAC_SEQ_BIAS_EN
  localparam int FIRST = 2;
`else
  localparam int FIRST = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_terms = '0;
  logic [CW-1:0] num_groups = '0;
  logic [MN-1:0] lane_mask = '0;
  logic          result_vld = 1'b0;
  logic          rd_en;
  logic [AW-1:0] img_addr;
  logic [AW-1:0] ker_addr;
  logic [MN-1:0] mac_en;
  logic [1:0]    psum_sel;
  logic          out_wr;
  logic [CW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic          err;

  mac_seq #(.MAC_NUM(MN), .CW(CW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_terms(num_terms), .num_groups(num_groups),
    .lane_mask(lane_mask), .result_vld(result_vld),
    .rd_en(rd_en), .img_addr(img_addr), .ker_addr(ker_addr),
    .mac_en(mac_en), .psum_sel(psum_sel), .out_wr(out_wr),
    .out_addr(out_addr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind; // 0 issue, 1 write, 2 done
    int            cyc;
    int            a;
    int            b;
    int            p;
    logic [MN-1:0] m;
    logic          e;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  rv_at = -1;
  bit  withhold = 0;
  bit  prev_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // array model: result arrives three cycles after the lane-enable pulse
  always @(posedge clk) begin
    #1;
    result_vld = (cyc == rv_at);
  end

  task automatic push_ev(int kind, int c, int a, int b, int p,
                         logic [MN-1:0] m, logic e);
    ev_t ev;
    ev.kind = kind; ev.cyc = c; ev.a = a; ev.b = b;
    ev.p = p; ev.m = m; ev.e = e;
    sbq.push_back(ev);
  endtask

  task automatic push_job(int c, int k, int g, logic [MN-1:0] m);
    int kk = (k == 0) ? 1 : k;
    int gg = (g == 0) ? 1 : g;
    int per = 5 * kk + 1;
    for (int gi = 0; gi < gg; gi++) begin
      for (int ti = 0; ti < kk; ti++)
        push_ev(0, c + 2 + gi * per + 5 * ti, (gi * kk + ti) % 65536, ti,
                (ti > 0) ? 1 : FIRST, m, 1'b0);
      push_ev(1, c + 1 + 5 * kk + gi * per, gi, 0, 0, '0, 1'b0);
    end
    push_ev(2, c + gg * per + 1, 0, 0, 0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && (|mac_en || out_wr || done)) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d mac_en=%0h out_wr=%0b done=%0b",
                 cyc, mac_en, out_wr, done);
      end else begin
        ev_t x;
        bit  ok;
        x = sbq.pop_front();
        case (x.kind)
          0: ok = |mac_en && !out_wr && !done && mac_en == x.m &&
                  int'(img_addr) == x.a && int'(ker_addr) == x.b &&
                  int'(psum_sel) == x.p && prev_rd;
          1: ok = out_wr && !(|mac_en) && !done && int'(out_addr) == x.a;
          default: ok = done && !out_wr && !(|mac_en) && !busy && err == x.e;
        endcase
        if (!ok || cyc != x.cyc) begin
          errors++;
          $display("FAIL event kind=%0d got cyc=%0d mac_en=%0h img=%0d ker=%0d psel=%0d rd_prev=%0b wr=%0b oaddr=%0d done=%0b busy=%0b err=%0b want cyc=%0d a=%0d b=%0d p=%0d m=%0h e=%0b",
                   x.kind, cyc, mac_en, img_addr, ker_addr, psum_sel, prev_rd,
                   out_wr, out_addr, done, busy, err,
                   x.cyc, x.a, x.b, x.p, x.m, x.e);
        end
      end
    end
    prev_rd = rd_en;
    if (!rst && |mac_en && !withhold) rv_at = cyc + 3;
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [MN-1:0] rnd_mask();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[$urandom_range(MN - 1, 0)] = 1'b1;
    return r[MN-1:0];
  endfunction

  // drives a one-cycle start; returns at the first cycle after it
  task automatic issue_start(int k, int g, logic [MN-1:0] m, output int c);
    @(posedge clk); #1;
    num_terms  = CW'(k);
    num_groups = CW'(g);
    lane_mask  = m;
    start      = 1'b1;
    c          = cyc;
    @(posedge clk); #1;
    start      = 1'b0;
    num_terms  = CW'($urandom);
    num_groups = CW'($urandom);
    lane_mask  = rnd_mask();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d", sbq.size());
      sbq.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic run_job(int k, int g, logic [MN-1:0] m);
    int c;
    issue_start(k, g, m, c);
    push_job(c, k, g, m);
    wait_drain();
  endtask

  initial begin
    int c;
    logic [MN-1:0] m;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_img_addr", img_addr, 0);
    chk("rst_ker_addr", ker_addr, 0);
    chk("rst_psum_sel", psum_sel, 0);
    chk("rst_out_addr", out_addr, 0);

    // K=3 G=2 reference job
    run_job(3, 2, rnd_mask());
    // zero counts behave as one
    run_job(0, 0, rnd_mask());
    // first-term partial-sum source
    run_job(2, 1, rnd_mask());

    for (int i = 0; i < 8; i++)
      run_job($urandom_range(4, 1), $urandom_range(3, 1), rnd_mask());

    // start during WAIT must not disturb the running job
    m = rnd_mask();
    issue_start(2, 2, m, c);
    push_job(c, 2, 2, m);
    repeat (2) @(posedge clk); #1;
    num_terms = CW'(7); num_groups = CW'(5); lane_mask = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();

    // reset in the second term's WAIT
    m = rnd_mask();
    issue_start(3, 2, m, c);
    push_ev(0, c + 2, 0, 0, FIRST, m, 1'b0);
    push_ev(0, c + 7, 1, 1, 1, m, 1'b0);
    repeat (7) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_mac_en", mac_en, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_out_wr", out_wr, 0);
    chk("midrst_done", done, 0);
    chk("midrst_img_addr", img_addr, 0);
    chk("midrst_ker_addr", ker_addr, 0);
    chk("midrst_psum_sel", psum_sel, 0);
    chk("midrst_out_addr", out_addr, 0);
    repeat (12) @(posedge clk); #1;
    chk("midrst_sb_empty", sbq.size(), 0);
    chk("midrst_idle", busy, 0);

    // withheld result: timeout aborts the job
    withhold = 1;
    m = rnd_mask();
    issue_start(2, 1, m, c);
    push_ev(0, c + 2, 0, 0, FIRST, m, 1'b0);
    push_ev(2, c + 7, 0, 0, 0, '0, 1'b1);
    wait_drain();
    withhold = 0;
    #1;
    chk("timeout_err_sticky", err, 1);
    chk("timeout_idle", busy, 0);
    m = rnd_mask();
    issue_start(2, 2, m, c);
    push_job(c, 2, 2, m);
    chk("restart_err_clr", err, 0);
    wait_drain();

    chk("final_sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
